// File: rtl/display_pkg.sv
// Shared types and constants for the display / game-logic blocks.
// Holds the frame update scheduler's default client count, index type and state encoding.
package display_pkg;

    localparam int SCHED_N_CLIENTS = 4;

    function automatic int sched_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [sched_idx_w(SCHED_N_CLIENTS)-1:0] client_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } sched_state_t;

endpackage

// File: rtl/sched_budget_timer.sv
// Per-client cycle budget timer for frame_update_sched.
// Down-counter loaded with BUDGET_CYC-1 on clear; expire_o marks the enabled cycle at terminal count.
module sched_budget_timer #(
    parameter int BUDGET_CYC = 4096,
    parameter int TMR_W      = 13
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TMR_W-1:0] LOAD = TMR_W'(BUDGET_CYC - 1);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    assign expire_o = enable_i && (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_update_sched.sv
// Per-frame scheduler: on each vsync falling edge, strobes enabled update clients in index order.
// Optional SCHED_STATS_EN adds max_lat_o (worst frame-start to frame_done latency, saturating).
//
// state | meaning
// IDLE  | waiting for a vsync falling edge with enable_i set
// ISSUE | strobe client idx if masked in, else skip it
// WAIT  | waiting for done_i[idx] or budget expiry
// DONE  | pulse frame_done_o, bump frame counter
module frame_update_sched
    import display_pkg::*;
#(
    parameter int N_CLIENTS  = SCHED_N_CLIENTS,
    parameter int BUDGET_CYC = 4096,
    parameter int TMR_W      = 13,
    parameter int FCNT_W     = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                vsync_i,
    input  logic                                enable_i,
    input  logic [N_CLIENTS-1:0]                client_mask_i,
    input  logic [N_CLIENTS-1:0]                done_i,
    output logic [N_CLIENTS-1:0]                start_o,
    output logic                                busy_o,
    output logic                                frame_done_o,
    output logic                                timeout_o,
    output logic [sched_idx_w(N_CLIENTS)-1:0]   timeout_id_o,
    output logic                                overrun_o,
    output logic [FCNT_W-1:0]                   frame_cnt_o
`ifdef SCHED_STATS_EN
    ,
    output logic [TMR_W+$clog2(N_CLIENTS):0]    max_lat_o
`endif
);

    localparam int IDX_W = sched_idx_w(N_CLIENTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);

    sched_state_t state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_CLIENTS-1:0] start_q, start_d;
    logic                 busy_q;
    logic                 frame_done_q, frame_done_d;
    logic                 timeout_q, timeout_d;
    logic [IDX_W-1:0]     timeout_id_q, timeout_id_d;
    logic                 overrun_q, overrun_d;
    logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                 vsync_q;
    logic                 first_q, first_d;
    logic                 frame_start;
    logic                 tmr_clear, tmr_en, tmr_expire;
    logic                 done_ok;

    sched_budget_timer #(
        .BUDGET_CYC (BUDGET_CYC),
        .TMR_W      (TMR_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (tmr_clear),
        .enable_i (tmr_en),
        .expire_o (tmr_expire)
    );

    assign frame_start = vsync_q && !vsync_i;
    // A done in the strobe's own cycle is too early to be a real answer.
    assign done_ok     = done_i[idx_q] && !first_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        start_d      = '0;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        overrun_d    = frame_start && (state_q != IDLE);
        frame_cnt_d  = frame_cnt_q;
        first_d      = 1'b0;
        tmr_clear    = 1'b0;
        tmr_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start && enable_i) begin
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (client_mask_i[idx_q]) begin
                    start_d   = N_CLIENTS'(1) << idx_q;
                    tmr_clear = 1'b1;
                    first_d   = 1'b1;
                    state_d   = WAIT;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT: begin
                tmr_en = 1'b1;
                if (done_ok || tmr_expire) begin
                    if (!done_ok) begin
                        timeout_d    = 1'b1;
                        timeout_id_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            start_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
            vsync_q      <= 1'b1;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            start_q      <= start_d;
            busy_q       <= (state_d != IDLE);
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
            vsync_q      <= vsync_i;
            first_q      <= first_d;
        end
    end

    assign start_o      = start_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign timeout_o    = timeout_q;
    assign timeout_id_o = timeout_id_q;
    assign overrun_o    = overrun_q;
    assign frame_cnt_o  = frame_cnt_q;

`ifdef SCHED_STATS_EN
    localparam int LAT_W = TMR_W + $clog2(N_CLIENTS) + 1;

    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LAT_W-1:0] max_lat_q, max_lat_d;

    // lat_q equals the frame-start to frame_done_o distance when sampled in DONE.
    always_comb begin
        lat_d     = lat_q;
        max_lat_d = max_lat_q;
        if (state_q == IDLE) begin
            lat_d = LAT_W'(1);
        end else if (lat_q != '1) begin
            lat_d = lat_q + LAT_W'(1);
        end
        if ((state_q == DONE) && (lat_q > max_lat_q)) begin
            max_lat_d = lat_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lat_q     <= '0;
            max_lat_q <= '0;
        end else begin
            lat_q     <= lat_d;
            max_lat_q <= max_lat_d;
        end
    end

    assign max_lat_o = max_lat_q;
`endif

endmodule

// File: tb/tb_frame_update_sched.sv
// Directed bench for frame_update_sched (N_CLIENTS=4, BUDGET_CYC=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_frame_update_sched;

    localparam int N  = 4;
    localparam int BUD = 16;
    localparam int TW = 5;
    localparam int FW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          vsync_i;
    logic          enable_i;
    logic [N-1:0]  client_mask_i;
    logic [N-1:0]  done_i;
    logic [N-1:0]  start_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          timeout_o;
    logic [1:0]    timeout_id_o;
    logic          overrun_o;
    logic [FW-1:0] frame_cnt_o;
`ifdef SCHED_STATS_EN
    logic [TW+2:0] max_lat_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    frame_update_sched #(
        .N_CLIENTS  (N),
        .BUDGET_CYC (BUD),
        .TMR_W      (TW),
        .FCNT_W     (FW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .vsync_i       (vsync_i),
        .enable_i      (enable_i),
        .client_mask_i (client_mask_i),
        .done_i        (done_i),
        .start_o       (start_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .timeout_o     (timeout_o),
        .timeout_id_o  (timeout_id_o),
        .overrun_o     (overrun_o),
        .frame_cnt_o   (frame_cnt_o)
`ifdef SCHED_STATS_EN
        ,
        .max_lat_o     (max_lat_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic vsync_fall();
        vsync_i = 1'b0;
        tick();
        vsync_i = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"},    32'(start_o),      0);
        chk({tag, "_busy"},     32'(busy_o),       0);
        chk({tag, "_fdone"},    32'(frame_done_o), 0);
        chk({tag, "_timeout"},  32'(timeout_o),    0);
        chk({tag, "_tid"},      32'(timeout_id_o), 0);
        chk({tag, "_overrun"},  32'(overrun_o),    0);
        chk({tag, "_fcnt"},     32'(frame_cnt_o),  0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        vsync_i       = 1'b1;
        enable_i      = 1'b1;
        client_mask_i = 4'b1111;
        done_i        = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_ni = 1'b1;
        tick();

        // Full mask, each client answers on the third edge after its strobe.
        vsync_fall();
        chk("t1_busy", 32'(busy_o), 1);
        for (int c = 0; c < N; c++) begin
            tick();
            chk($sformatf("t1_start%0d", c), 32'(start_o), 32'(1 << c));
            tick();
            chk($sformatf("t1_strobe_len%0d", c), 32'(start_o), 0);
            tick();
            done_i = 4'(1 << c);
            tick();
            done_i = '0;
        end
        tick();
        chk("t1_fdone", 32'(frame_done_o), 1);
        chk("t1_fcnt", 32'(frame_cnt_o), 1);
        chk("t1_busy_end", 32'(busy_o), 0);
        tick();
        chk("t1_fdone_len", 32'(frame_done_o), 0);

        // Mask 0101; a done in the strobe's own cycle must be ignored.
        client_mask_i = 4'b0101;
        vsync_fall();
        tick();
        chk("t2_start0", 32'(start_o), 32'h1);
        done_i = 4'b0001;
        tick();
        chk("t2_s1", 32'(start_o), 0);
        tick();
        done_i = '0;
        chk("t2_s2", 32'(start_o), 0);
        tick();
        chk("t2_skip1", 32'(start_o), 0);
        tick();
        chk("t2_start2", 32'(start_o), 32'h4);
        tick();
        done_i = 4'b0100;
        tick();
        done_i = '0;
        chk("t2_s7", 32'(start_o), 0);
        tick();
        chk("t2_skip3", 32'(start_o), 0);
        chk("t2_fdone_early", 32'(frame_done_o), 0);
        tick();
        chk("t2_fdone", 32'(frame_done_o), 1);
        chk("t2_fcnt", 32'(frame_cnt_o), 2);
        tick();
        chk("t2_fdone_len", 32'(frame_done_o), 0);

        // Stray done_i[3] during client 0, timeout on client 1, overrun during client 2.
        client_mask_i = 4'b1111;
        vsync_fall();
        tick();
        chk("t3_start0", 32'(start_o), 32'h1);
        tick();
        done_i = 4'b1000;
        tick();
        done_i = 4'b0001;
        tick();
        done_i = '0;
        chk("t3_done3_ignored", 32'(start_o), 0);
        tick();
        chk("t3_start1", 32'(start_o), 32'h2);
        repeat (15) tick();
        chk("t3_no_early_timeout", 32'(timeout_o), 0);
        tick();
        chk("t3_timeout", 32'(timeout_o), 1);
        chk("t3_tid", 32'(timeout_id_o), 1);
        tick();
        chk("t3_start2", 32'(start_o), 32'h4);
        chk("t3_timeout_len", 32'(timeout_o), 0);
        vsync_i = 1'b0;
        tick();
        vsync_i = 1'b1;
        chk("t3_overrun", 32'(overrun_o), 1);
        done_i = 4'b0100;
        tick();
        done_i = '0;
        chk("t3_overrun_len", 32'(overrun_o), 0);
        tick();
        chk("t3_start3", 32'(start_o), 32'h8);
        tick();
        done_i = 4'b1000;
        tick();
        done_i = '0;
        tick();
        chk("t3_fdone", 32'(frame_done_o), 1);
        chk("t3_fcnt", 32'(frame_cnt_o), 3);
        tick();
        chk("t3_busy_end", 32'(busy_o), 0);
        chk("t3_no_restart", 32'(start_o), 0);
        chk("t3_tid_held", 32'(timeout_id_o), 1);

        // Disabled frame start ignored; then all clients masked.
        enable_i = 1'b0;
        vsync_fall();
        tick();
        chk("t4_disabled", 32'(busy_o), 0);
        enable_i = 1'b1;
        client_mask_i = 4'b0000;
        vsync_fall();
        repeat (4) tick();
        chk("t4_fdone_early", 32'(frame_done_o), 0);
        chk("t4_no_strobe", 32'(start_o), 0);
        tick();
        chk("t4_fdone", 32'(frame_done_o), 1);
        chk("t4_fcnt", 32'(frame_cnt_o), 4);
        tick();

        // Done and expiry together on client 1, then reset during client 2.
        client_mask_i = 4'b1111;
        vsync_fall();
        tick();
        chk("t5_start0", 32'(start_o), 32'h1);
        tick();
        done_i = 4'b0001;
        tick();
        done_i = '0;
        tick();
        chk("t5_start1", 32'(start_o), 32'h2);
        repeat (15) tick();
        done_i = 4'b0010;
        tick();
        done_i = '0;
        chk("t5_done_wins", 32'(timeout_o), 0);
        tick();
        chk("t5_start2", 32'(start_o), 32'h4);
        tick();
        rst_ni = 1'b0;
        tick();
        chk_all_zero("t5_rst");
        rst_ni = 1'b1;
        tick();
        tick();
        vsync_fall();
        tick();
        chk("t5_restart0", 32'(start_o), 32'h1);
        chk("t5_restart_busy", 32'(busy_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_update_sched.md
Name: frame_update_sched

Overview:
Per-frame scheduler that sequences game-logic update engines (paddles, ball, score) during vertical blanking.
- Detects frame start from the active-low vsync produced by the display timing generator.
- Issues a one-cycle start strobe to each enabled client in fixed index order, and waits for each client's done pulse before moving on.
- Enforces a per-client cycle budget.
- Reports frame completion, timeouts and overruns.

Parameters:
N_CLIENTS, 4, number of update clients (1..8)
BUDGET_CYC, 4096, max cycles a client may take before timeout (>=2)
TMR_W, 13, timer width; must hold BUDGET_CYC
FCNT_W, 16, frame counter width

Ports:
clk_i  in  1  pixel clock
rst_ni  in  1  reset, synchronous active-low
vsync_i  in  1  vsync from timing generator, active-low pulse
enable_i  in  1  global scheduler enable
client_mask_i  in  N_CLIENTS  1 = client participates this frame
done_i  in  N_CLIENTS  per-client completion pulse
start_o  out  N_CLIENTS  one-cycle start strobe, one-hot or zero
busy_o  out  1  sequence in progress (state != IDLE)
frame_done_o  out  1  one-cycle pulse when sequence ends
timeout_o  out  1  one-cycle pulse on client budget expiry
timeout_id_o  out  $clog2(N_CLIENTS) (min 1)  index of last timed-out client, held
overrun_o  out  1  one-cycle pulse: frame start while busy
frame_cnt_o  out  FCNT_W  completed sequences, wraps to 0

Behaviour:
- Reset (rst_ni=0 at clk edge): all outputs 0, state IDLE, vsync history register = 1.
- Frame start: vsync_q=1 and vsync_i=0, where vsync_q is vsync_i registered by one cycle.
- IDLE: on frame start with enable_i=1 -> idx=0, go ISSUE. With enable_i=0, frame start is ignored.
- ISSUE:
  - If client_mask_i[idx]=1: start_o[idx]=1 for exactly this cycle, timer=0, go WAIT.
  - Else skip with no strobe: go to the next idx, or to DONE if idx=N_CLIENTS-1. Each skipped client costs one cycle.
- WAIT:
  - timer increments each cycle.
  - done_i[idx]=1 -> next idx (ISSUE) or DONE.
  - Otherwise, if timer=BUDGET_CYC-1 -> timeout_o=1, timeout_id_o=idx, advance exactly as for done.
  - done_i and timeout in the same cycle: done wins, no timeout.
  - done_i bits for non-current clients are ignored, in all states.
  - done_i in the same cycle as its start_o is ignored; earliest accepted done is the cycle after the strobe.
- DONE: frame_done_o=1 for one cycle, frame_cnt_o+1 (wraps at 2^FCNT_W), go IDLE.
- Latency:
  - Frame start edge at cycle t -> start_o[0] at t+1, when mask bit 0 is set.
  - Registered done at t -> next start_o at t+1.
  - All clients masked: frame_done_o at t+1+N_CLIENTS.
- Overrun: frame start while state != IDLE pulses overrun_o. The current sequence continues and is not restarted; the missed frame is not queued.
- enable_i deasserted mid-sequence: the sequence runs to completion; only new frame starts are blocked.
- client_mask_i is sampled at each ISSUE visit, not latched per frame.
- Reset mid-sequence: immediate return to IDLE, start_o cleared, frame_cnt_o=0. A frame start in the first cycle after reset is impossible because the history register resets to 1.
- All outputs are registered; no combinational input->output paths.

Optional Feature:
SCHED_STATS_EN
- Defined: adds output max_lat_o [TMR_W+$clog2(N_CLIENTS)+1 bits].
  - Holds the maximum cycle count from frame start to frame_done_o observed since reset, saturating.
  - Updated in the DONE cycle.
  - Reset to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- display_pkg gains:
  - SCHED_N_CLIENTS default constant
  - client index typedef
  - sched_state_t enum {IDLE, ISSUE, WAIT, DONE}
- Sub-module sched_budget_timer:
  - Inputs: clear, enable.
  - Output: expire pulse at BUDGET_CYC-1.
  - Parameters: BUDGET_CYC, TMR_W.
- Edge detect and FSM remain in frame_update_sched.

Test Plan:
- N_CLIENTS=4, mask=4'b1111, each client returns done 3 cycles after its start.
  - start_o sequence 0001,0010,0100,1000, each 4 cycles apart.
  - frame_done_o 1 cycle after done[3].
  - frame_cnt_o=1.
- mask=4'b0101: strobes only on clients 0 and 2, no strobe on 1 or 3; frame_done_o pulses once.
- Client 1 never answers, BUDGET_CYC=16.
  - timeout_o 16 cycles after start_o[1].
  - timeout_id_o=1.
  - start_o[2] the next cycle.
- Second vsync falling edge while client 2 is in WAIT: overrun_o=1 for one cycle; sequence completes; frame_cnt_o increments by 1 only.
- done_i[1] and budget expiry in the same cycle for client 1: no timeout_o; advance to client 2. Also check that done_i[3] pulsed while client 0 is active is ignored.
- rst_ni low for 1 cycle during WAIT: next cycle all outputs 0, state IDLE. The next vsync falling edge restarts at client 0.
